// File: rtl/contador_pkg.sv
// Shared types and default sizes for the Contador lockstep checker.
//   chk_state_t : checker FSM encoding, also driven onto the 2-bit state port.
//   CNT_WIDTH   : default width of each counter value.
//   CNT_ERR_W   : default width of the saturating error/wrap counters.
package contador_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned CNT_ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the checker's error and wrap statistics.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one event this cycle
//   cnt      : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/contador_checker.sv
// Lockstep checker for two free-running counters (a, b). Both values are
// registered every clock, compared one stage later, and disagreement while
// tracking is counted, the first bad pair is captured, and a sticky fault is
// raised once the error count reaches ERR_LIMIT. Latency from inputs to
// outputs is two clock edges.
// Optional build macro: CONTADOR_CHECKER_STEP_CHECK_EN -- when defined, a
// sample whose `a` is not the previous `a` plus one is also an error in TRACK.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : sample enable (registered with the data)
//   clr        : synchronous clear of counters, capture and FSM
//   a, b       : counter values under comparison
//   match      : registered a==b for a valid sample
//   fault      : sticky fault (state == FAULT)
//   state      : current FSM state (chk_state_t encoding)
//   err_cnt    : saturating error count
//   wrap_cnt   : saturating count of `a` wrapping all-ones -> zero
//   first_a/_b : pair captured at the first counted error
//   first_vld  : capture above is valid
module contador_checker
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_WIDTH,
  parameter int unsigned ERR_W       = CNT_ERR_W,
  parameter int unsigned SYNC_CYCLES = 2,
  parameter int unsigned ERR_LIMIT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             match,
  output logic             fault,
  output logic [1:0]       state,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic             first_vld
);

  localparam int unsigned SC_W = $clog2(SYNC_CYCLES + 1);

  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic             r_v_q;
  logic [WIDTH-1:0] r_a_prev;
  logic             r_match;
  chk_state_t       r_state;
  chk_state_t       w_state_nxt;
  logic [SC_W-1:0]  r_sync_cnt;
  logic [SC_W-1:0]  w_sync_nxt;
  logic [WIDTH-1:0] r_first_a;
  logic [WIDTH-1:0] r_first_b;
  logic             r_first_vld;

  logic             w_eq;
  logic             w_bad_step;
  logic             w_tracking;
  logic             w_err_evt;
  logic             w_wrap_evt;
  logic [ERR_W-1:0] w_err_cnt;
  logic [ERR_W-1:0] w_wrap_cnt;
  logic [ERR_W-1:0] w_err_inc;

  // Stage 1: register the raw inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_q <= '0;
      r_b_q <= '0;
      r_v_q <= 1'b0;
    end else begin
      r_a_q <= a;
      r_b_q <= b;
      r_v_q <= en;
    end
  end

  assign w_eq       = (r_a_q == r_b_q);
  assign w_tracking = (r_state == TRACK) && r_v_q;

`ifdef CONTADOR_CHECKER_STEP_CHECK_EN
  assign w_bad_step = (r_a_q != WIDTH'(r_a_prev + WIDTH'(1)));
`else
  assign w_bad_step = 1'b0;
`endif

  // A sample that is both unequal and a bad step is still one event.
  assign w_err_evt  = w_tracking && (!w_eq || w_bad_step);
  assign w_wrap_evt = w_tracking && (r_a_prev == '1) && (r_a_q == '0);
  // Value err_cnt will hold after this event, used for the fault decision.
  assign w_err_inc  = (w_err_cnt == '1) ? w_err_cnt : w_err_cnt + ERR_W'(1);

  // Stage 2: match flag and previous-sample tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match  <= 1'b0;
      r_a_prev <= '0;
    end else begin
      r_match <= r_v_q && w_eq;
      if (r_v_q) begin
        r_a_prev <= r_a_q;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sync_nxt  = r_sync_cnt;
    case (r_state)
      IDLE: begin
        if (r_v_q) begin
          w_state_nxt = SYNC;
          w_sync_nxt  = '0;
        end
      end
      SYNC: begin
        if (!r_v_q) begin
          w_state_nxt = IDLE;
        end else if (w_eq) begin
          w_sync_nxt = r_sync_cnt + SC_W'(1);
          if (w_sync_nxt == SC_W'(SYNC_CYCLES)) begin
            w_state_nxt = TRACK;
          end
        end else begin
          w_sync_nxt = '0;
        end
      end
      TRACK: begin
        if (!r_v_q) begin
          w_state_nxt = IDLE;
        end else if (w_err_evt && (w_err_inc >= ERR_W'(ERR_LIMIT))) begin
          w_state_nxt = FAULT;
        end
      end
      FAULT: w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase
    if (clr) begin
      w_state_nxt = IDLE;
      w_sync_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sync_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync_cnt <= w_sync_nxt;
    end
  end

  // First-error capture; later errors never overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first_a   <= '0;
      r_first_b   <= '0;
      r_first_vld <= 1'b0;
    end else if (clr) begin
      r_first_a   <= '0;
      r_first_b   <= '0;
      r_first_vld <= 1'b0;
    end else if (w_err_evt && !r_first_vld) begin
      r_first_a   <= r_a_q;
      r_first_b   <= r_b_q;
      r_first_vld <= 1'b1;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_err_evt),
    .cnt (w_err_cnt)
  );

  sat_counter #(.W(ERR_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_wrap_evt),
    .cnt (w_wrap_cnt)
  );

  assign match     = r_match;
  assign fault     = (r_state == FAULT);
  assign state     = r_state;
  assign err_cnt   = w_err_cnt;
  assign wrap_cnt  = w_wrap_cnt;
  assign first_a   = r_first_a;
  assign first_b   = r_first_b;
  assign first_vld = r_first_vld;

endmodule

// File: tb/tb_contador_checker.sv
// Scoreboard bench for contador_checker: each driven vector may push an
// expected output record due two edges later; a negedge monitor pops and
// compares the selected fields.
module tb_contador_checker;
  import contador_pkg::*;

`ifdef CONTADOR_CHECKER_STEP_CHECK_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif

  localparam int M_MA = 1, M_ST = 2, M_ER = 4, M_WR = 8, M_FI = 16, M_FL = 32;
  localparam int M_ALL = 63;

  typedef struct {
    int due;
    int id;
    int m;
    int ma, st, er, wr, fa, fb, fv, fl;
  } exp_t;

  logic       clk;
  logic       rst, en, clr;
  logic [3:0] a, b;
  logic       match, fault, first_vld;
  logic [1:0] state;
  logic [7:0] err_cnt, wrap_cnt;
  logic [3:0] first_a, first_b;

  int   cyc = 0;
  int   drv_cyc = 0;
  int   k = 0;
  int   k_last = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] cv;
  exp_t sb[$];

  contador_checker #(
    .WIDTH       (4),
    .ERR_W       (8),
    .SYNC_CYCLES (2),
    .ERR_LIMIT   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .a         (a),
    .b         (b),
    .match     (match),
    .fault     (fault),
    .state     (state),
    .err_cnt   (err_cnt),
    .wrap_cnt  (wrap_cnt),
    .first_a   (first_a),
    .first_b   (first_b),
    .first_vld (first_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", nm, id, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                       input logic ven, input logic vclr);
    @(posedge clk);
    #1;
    a = va; b = vb; en = ven; clr = vclr;
    drv_cyc = cyc;
    k_last = k;
    k++;
  endtask

  task automatic run_eq(input int n);
    for (int i = 0; i < n; i++) begin
      drive(cv, cv, 1'b1, 1'b0);
      cv++;
    end
  endtask

  task automatic exp_out(input int m, input int ma, input int st, input int er,
                         input int wr, input int fa, input int fb, input int fv,
                         input int fl);
    exp_t e;
    e.due = drv_cyc + 2; e.id = k_last; e.m = m;
    e.ma = ma; e.st = st; e.er = er; e.wr = wr;
    e.fa = fa; e.fb = fb; e.fv = fv; e.fl = fl;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_match"}, -1, int'(match), 0);
    chk({tag, "_fault"}, -1, int'(fault), 0);
    chk({tag, "_state"}, -1, int'(state), 0);
    chk({tag, "_err"}, -1, int'(err_cnt), 0);
    chk({tag, "_wrap"}, -1, int'(wrap_cnt), 0);
    chk({tag, "_first_a"}, -1, int'(first_a), 0);
    chk({tag, "_first_b"}, -1, int'(first_b), 0);
    chk({tag, "_first_vld"}, -1, int'(first_vld), 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    chk("sb_drain", -1, sb.size(), 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          chk("sb_stale", e.id, e.due, cyc);
        end else begin
          if ((e.m & M_MA) != 0) chk("match", e.id, int'(match), e.ma);
          if ((e.m & M_ST) != 0) chk("state", e.id, int'(state), e.st);
          if ((e.m & M_ER) != 0) chk("err_cnt", e.id, int'(err_cnt), e.er);
          if ((e.m & M_WR) != 0) chk("wrap_cnt", e.id, int'(wrap_cnt), e.wr);
          if ((e.m & M_FI) != 0) begin
            chk("first_a", e.id, int'(first_a), e.fa);
            chk("first_b", e.id, int'(first_b), e.fb);
            chk("first_vld", e.id, int'(first_vld), e.fv);
          end
          if ((e.m & M_FL) != 0) chk("fault", e.id, int'(fault), e.fl);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = '0; b = '0; cv = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Identical counters from reset release.
    for (int i = 0; i < 40; i++) begin
      drive(cv, cv, 1'b1, 1'b0);
      cv++;
      if (i == 0)  exp_out(M_MA | M_ST, 1, int'(SYNC), 0, 0, 0, 0, 0, 0);
      if (i == 1)  exp_out(M_ST, 0, int'(SYNC), 0, 0, 0, 0, 0, 0);
      if (i == 2)  exp_out(M_ST, 0, int'(TRACK), 0, 0, 0, 0, 0, 0);
      if (i == 15) exp_out(M_WR, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i == 16) exp_out(M_WR, 0, 0, 0, 1, 0, 0, 0, 0);
      if (i == 39) exp_out(M_MA | M_ST | M_ER | M_WR | M_FL, 1, int'(TRACK), 0, 2, 0, 0, 0, 0);
    end

    // Single disturbance a=5/b=6, then a second mismatch a=9/b=2.
    run_eq(13);
    drive(4'd5, 4'd6, 1'b1, 1'b0);
    exp_out(M_MA | M_ST | M_ER | M_WR | M_FI, 0, int'(TRACK), 1, 3, 5, 6, 1, 0);
    cv = 4'd6;
    drive(cv, cv, 1'b1, 1'b0); cv++;
    exp_out(M_MA | M_ER, 1, 0, 1, 0, 0, 0, 0, 0);
    run_eq(2);
    drive(4'd9, 4'd2, 1'b1, 1'b0);
    exp_out(M_MA | M_ER | M_FI, 0, 0, 2, 0, 5, 6, 1, 0);
    cv = 4'd10;
    drive(cv, cv, 1'b1, 1'b0); cv++;
    exp_out(M_MA | M_ST | M_ER | M_WR, 1, int'(TRACK), 2, 3, 0, 0, 0, 0);

    // en low for three samples, then re-sync.
    for (int i = 0; i < 3; i++) begin
      drive(cv, cv, 1'b0, 1'b0);
      cv++;
      if (i == 0) exp_out(M_MA | M_ST, 0, int'(IDLE), 0, 0, 0, 0, 0, 0);
      if (i == 2) exp_out(M_ST | M_ER | M_WR | M_FI, 0, int'(IDLE), 2, 3, 5, 6, 1, 0);
    end
    run_eq(1); exp_out(M_ST, 0, int'(SYNC), 0, 0, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ST, 0, int'(SYNC), 0, 0, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ST | M_WR, 0, int'(TRACK), 0, 3, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ST | M_ER, 0, int'(TRACK), 2, 0, 0, 0, 0, 0);

    // Counter `a` jumps 3 -> 7 with b equal.
    run_eq(2);
    cv = 4'd7;
    drive(cv, cv, 1'b1, 1'b0); cv++;
    exp_out(M_MA | M_ST | M_ER, 1, int'(TRACK), 2 + STEP, 0, 0, 0, 0, 0);
    // The next vector's evaluation edge is the clr edge.
    drive(cv, cv, 1'b1, 1'b0); cv++;
    exp_out(M_ALL, 1, int'(IDLE), 0, 0, 0, 0, 0, 0);
    drive(cv, cv, 1'b1, 1'b1); cv++;
    exp_out(M_ST | M_ER, 0, int'(SYNC), 0, 0, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ST, 0, int'(SYNC), 0, 0, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ST | M_ER | M_FL, 0, int'(TRACK), 0, 0, 0, 0, 0, 0);

    // Four mismatches reach ERR_LIMIT.
    drive(4'd12, 4'd13, 1'b1, 1'b0);
    exp_out(M_ER | M_FI, 0, 0, 1, 0, 12, 13, 1, 0);
    drive(4'd13, 4'd12, 1'b1, 1'b0);
    exp_out(M_ER, 0, 0, 2, 0, 0, 0, 0, 0);
    drive(4'd14, 4'd15, 1'b1, 1'b0);
    exp_out(M_ST | M_ER | M_FL, 0, int'(TRACK), 3, 0, 0, 0, 0, 0);
    drive(4'd15, 4'd14, 1'b1, 1'b0);
    exp_out(M_ST | M_ER | M_FL | M_FI, 0, int'(FAULT), 4, 0, 12, 13, 1, 1);
    cv = 4'd0;
    for (int i = 0; i < 3; i++) begin
      drive(cv, cv, 1'b0, 1'b0);
      cv++;
      if (i < 2) exp_out(M_MA | M_ST | M_ER | M_FL, 0, int'(FAULT), 4, 0, 0, 0, 0, 1);
      else       exp_out(M_ALL, 0, int'(IDLE), 0, 0, 0, 0, 0, 0);
    end
    drive(cv, cv, 1'b1, 1'b1); cv++;
    exp_out(M_ST, 0, int'(SYNC), 0, 0, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ST, 0, int'(SYNC), 0, 0, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ST | M_ER | M_WR | M_FL, 0, int'(TRACK), 0, 0, 0, 0, 0, 0);

    // Build err_cnt=3, wrap_cnt=1, then async reset mid-TRACK.
    run_eq(2);
    for (int i = 0; i < 3; i++) begin
      drive(cv, cv + 4'd1, 1'b1, 1'b0);
      cv++;
    end
    exp_out(M_ST | M_ER | M_FI, 0, int'(TRACK), 3, 0, 8, 9, 1, 0);
    run_eq(4);
    run_eq(1); exp_out(M_WR, 0, 0, 0, 0, 0, 0, 0, 0);
    run_eq(1); exp_out(M_WR, 0, 0, 0, 1, 0, 0, 0, 0);
    run_eq(1); exp_out(M_ALL, 1, int'(TRACK), 3, 1, 8, 9, 1, 0);
    run_eq(2);
    drain();

    @(posedge clk);
    #2;
    rst = 1'b1;
    en = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst = 1'b0;

    run_eq(1); exp_out(M_MA | M_ST | M_ER | M_WR, 1, int'(SYNC), 0, 0, 0, 0, 0, 0);
    run_eq(1);
    run_eq(1); exp_out(M_ST | M_FL, 0, int'(TRACK), 0, 0, 0, 0, 0, 0);
    run_eq(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
